// File: rtl/sobel_frame_writer.sv
// ---------------------------------------------------------------------------
// sobel_frame_writer
//
// Drains the sobel output FIFO (show-ahead) and writes one frame of
// IMG_WIDTH x IMG_HEIGHT pixels into a frame-memory write port at sequential
// addresses 0 .. IMG_WIDTH*IMG_HEIGHT-1. A start pulse in IDLE arms a frame.
// After the write to the last address is accepted, frame_done pulses for one
// cycle and the block returns to IDLE.
//
// Ports
//   clock          in   rising-edge clock
//   reset          in   asynchronous, active-low reset
//   start          in   one-cycle pulse, arms a frame when idle
//   fifo_in_rd_en  out  pops the FIFO head this cycle (combinational)
//   fifo_in_dout   in   FIFO head data, valid while fifo_in_empty = 0
//   fifo_in_empty  in   FIFO has no data
//   mem_wr_en      out  write request valid (registered holding stage)
//   mem_wr_addr    out  write address
//   mem_wr_data    out  write data
//   mem_ready      in   memory accepts the request when mem_wr_en = 1
//   busy           out  high while a frame is being transferred
//   frame_done     out  one-cycle pulse after the final write is accepted
// ---------------------------------------------------------------------------
module sobel_frame_writer #(
  parameter int unsigned IMG_WIDTH  = 720,
  parameter int unsigned IMG_HEIGHT = 540,
  parameter int unsigned DWIDTH     = 8,
  parameter int unsigned ADDR_WIDTH = 20
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  fifo_in_rd_en,
  input  logic [DWIDTH-1:0]     fifo_in_dout,
  input  logic                  fifo_in_empty,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DWIDTH-1:0]     mem_wr_data,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned FRAME_SIZE = IMG_WIDTH * IMG_HEIGHT;
  // Counter must be able to hold FRAME_SIZE itself (the "frame complete" value).
  localparam int unsigned CNT_W      = $clog2(FRAME_SIZE + 1);

  localparam logic [CNT_W-1:0]      FRAME_PIXELS = CNT_W'(FRAME_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR    = ADDR_WIDTH'(FRAME_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] pop_count;
  logic             stage_free;
  logic             pop;
  logic             last_accept;

  // The holding stage can take a new pixel when it is empty or being drained now.
  assign stage_free  = ~mem_wr_en | mem_ready;

  // Pop only while running, data available, frame not yet fully popped, and room.
  assign pop = (state == S_RUN) & ~fifo_in_empty & (pop_count < FRAME_PIXELS) & stage_free;

  assign fifo_in_rd_en = pop;

  // Final write of the frame accepted by the memory this cycle.
  assign last_accept = (state == S_RUN) & mem_wr_en & mem_ready & (mem_wr_addr == LAST_ADDR);

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = S_RUN;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_accept) begin
          next_state = S_DONE;
        end else begin
          next_state = S_RUN;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // State register plus registered status outputs derived from the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= next_state;
      busy       <= (next_state == S_RUN);
      frame_done <= (next_state == S_DONE);
    end
  end

  // Pop counter and the write holding stage (en/addr/data).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pop_count   <= {CNT_W{1'b0}};
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= {ADDR_WIDTH{1'b0}};
      mem_wr_data <= {DWIDTH{1'b0}};
    end else begin
      case (state)
        S_IDLE: begin
          mem_wr_en <= 1'b0;
          if (start) begin
            pop_count   <= {CNT_W{1'b0}};
            mem_wr_addr <= {ADDR_WIDTH{1'b0}};
          end
        end
        S_RUN: begin
          if (pop) begin
            // Refill: may coincide with acceptance of the previous pixel.
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= ADDR_WIDTH'(pop_count);
            mem_wr_data <= fifo_in_dout;
            pop_count   <= pop_count + CNT_W'(1);
          end else if (stage_free) begin
            mem_wr_en <= 1'b0;
          end
          // Stage full and stalled: en/addr/data hold their values.
        end
        S_DONE: begin
          mem_wr_en <= 1'b0;
        end
        default: begin
          mem_wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_frame_writer.sv
// ---------------------------------------------------------------------------
// Self-checking bench for sobel_frame_writer with a 4x3 frame.
// A FIFO is modelled as a queue; a transaction-level reference model tracks
// the pending write, pops per frame and completion, and every cycle the DUT
// outputs are compared with it. Scenario records drive the main frames.
// ---------------------------------------------------------------------------
module tb_sobel_frame_writer;

  localparam int W     = 4;
  localparam int H     = 3;
  localparam int TOTAL = W * H;
  localparam int DW    = 8;
  localparam int AW    = 20;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          fifo_in_rd_en;
  logic [DW-1:0] fifo_in_dout;
  logic          fifo_in_empty;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_ready;
  logic          busy;
  logic          frame_done;

  always #5 clock = ~clock;

  sobel_frame_writer #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .DWIDTH    (DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .fifo_in_rd_en(fifo_in_rd_en),
    .fifo_in_dout (fifo_in_dout),
    .fifo_in_empty(fifo_in_empty),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_ready    (mem_ready),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  int errors = 0;
  int checks = 0;

  // FIFO contents seen by the DUT
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] next_pixel = 8'h00;

  // Reference model (transaction level)
  bit            m_running = 1'b0;
  bit            m_done    = 1'b0;
  bit            m_valid   = 1'b0;
  int            m_pops    = 0;
  int            m_addr    = 0;
  logic [DW-1:0] m_data    = 8'h00;
  int            writes_seen = 0;
  int            done_seen   = 0;

  typedef struct {
    int preload;      // pixels pushed before start
    int feed_period;  // 0: no feeding during the frame
    int feed_count;   // pixels fed during the frame
    int ready_mode;   // 0: always 1, 1: 1,0,0,1 pattern, 2: random
    bit extra_start;  // extra start pulses while running
    int exp_writes;
    int exp_done;
    int exp_left;     // pixels left in the FIFO afterwards
  } scen_t;

  scen_t scen[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic update_pins();
    fifo_in_empty = (fifo_q.size() == 0);
    fifo_in_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h5A;
  endtask

  // One clock cycle: entered at posedge+1, left at the next posedge+1.
  task automatic step(input bit st, input bit rdy, input bit push);
    bit exp_rd;
    bit accept;
    start     = st;
    mem_ready = rdy;
    if (push) begin
      fifo_q.push_back(next_pixel);
      next_pixel = next_pixel + 8'h01;
    end
    update_pins();
    @(negedge clock);
    exp_rd = m_running && (fifo_q.size() > 0) && (m_pops < TOTAL) && (!m_valid || rdy);
    check("rd_en", {31'd0, fifo_in_rd_en}, {31'd0, exp_rd});
    check("wr_en", {31'd0, mem_wr_en}, {31'd0, m_valid});
    check("busy", {31'd0, busy}, {31'd0, m_running});
    check("frame_done", {31'd0, frame_done}, {31'd0, m_done});
    if (m_valid) begin
      check("wr_addr", {12'd0, mem_wr_addr}, 32'(m_addr));
      check("wr_data", {24'd0, mem_wr_data}, {24'd0, m_data});
    end
    // advance the model across the coming edge
    accept = m_running && m_valid && rdy;
    if (m_done) begin
      m_done = 1'b0;
    end else if (!m_running) begin
      if (st) begin
        m_running = 1'b1;
        m_pops    = 0;
      end
    end else begin
      if (accept) writes_seen++;
      if (accept && m_addr == TOTAL - 1) begin
        m_running = 1'b0;
        m_done    = 1'b1;
        done_seen++;
      end
      if (exp_rd) begin
        m_valid = 1'b1;
        m_addr  = m_pops;
        m_data  = fifo_q.pop_front();
        m_pops++;
      end else if (!m_valid || rdy) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clock);
    #1;
    update_pins();
  endtask

  task automatic run_frame(input scen_t s);
    int d0;
    int w0;
    int cyc;
    int fed;
    int post;
    bit rdy;
    bit push;
    bit st;
    d0 = done_seen;
    w0 = writes_seen;
    cyc = 0;
    fed = 0;
    post = 0;
    for (int i = 0; i < s.preload; i++) begin
      fifo_q.push_back(next_pixel);
      next_pixel = next_pixel + 8'h01;
    end
    while (post < 3 && cyc < 400) begin
      st = (cyc == 0) || (s.extra_start && (cyc == 3 || cyc == 7 || cyc == 10));
      case (s.ready_mode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        2: rdy = 1'($urandom_range(0, 1));
        default: rdy = 1'b1;
      endcase
      push = (s.feed_period > 0) && (fed < s.feed_count) && (cyc % s.feed_period == s.feed_period - 1);
      if (push) fed++;
      step(st, rdy, push);
      if (done_seen != d0) post++;
      cyc++;
    end
    check("frame_writes", 32'(writes_seen - w0), 32'(s.exp_writes));
    check("frame_done_count", 32'(done_seen - d0), 32'(s.exp_done));
    check("fifo_left", 32'(fifo_q.size()), 32'(s.exp_left));
  endtask

  initial begin
    scen[0] = '{preload: 12, feed_period: 0, feed_count: 0, ready_mode: 0, extra_start: 1'b0, exp_writes: 12, exp_done: 1, exp_left: 0};
    scen[1] = '{preload: 12, feed_period: 0, feed_count: 0, ready_mode: 1, extra_start: 1'b0, exp_writes: 12, exp_done: 1, exp_left: 0};
    scen[2] = '{preload: 0,  feed_period: 3, feed_count: 12, ready_mode: 0, extra_start: 1'b0, exp_writes: 12, exp_done: 1, exp_left: 0};
    scen[3] = '{preload: 15, feed_period: 0, feed_count: 0, ready_mode: 0, extra_start: 1'b0, exp_writes: 12, exp_done: 1, exp_left: 3};
    scen[4] = '{preload: 0,  feed_period: 1, feed_count: 9, ready_mode: 2, extra_start: 1'b0, exp_writes: 12, exp_done: 1, exp_left: 0};
    scen[5] = '{preload: 12, feed_period: 0, feed_count: 0, ready_mode: 1, extra_start: 1'b1, exp_writes: 12, exp_done: 1, exp_left: 0};

    reset     = 1'b0;
    start     = 1'b0;
    mem_ready = 1'b0;
    update_pins();
    #2;
    check("reset_rd_en", {31'd0, fifo_in_rd_en}, 32'd0);
    check("reset_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check("reset_wr_addr", {12'd0, mem_wr_addr}, 32'd0);
    check("reset_wr_data", {24'd0, mem_wr_data}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_frame_done", {31'd0, frame_done}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    step(1'b0, 1'b1, 1'b0);

    // table-driven frames
    for (int i = 0; i < 6; i++) begin
      run_frame(scen[i]);
    end

    // reset after the 5th accepted write
    begin
      int w0;
      int guard;
      w0 = writes_seen;
      guard = 0;
      for (int i = 0; i < 12; i++) begin
        fifo_q.push_back(next_pixel);
        next_pixel = next_pixel + 8'h01;
      end
      step(1'b1, 1'b1, 1'b0);
      while (writes_seen - w0 < 5 && guard < 50) begin
        step(1'b0, 1'b1, 1'b0);
        guard++;
      end
      check("writes_before_reset", 32'(writes_seen - w0), 32'd5);
      reset = 1'b0;
      #1;
      check("midreset_rd_en", {31'd0, fifo_in_rd_en}, 32'd0);
      check("midreset_wr_en", {31'd0, mem_wr_en}, 32'd0);
      check("midreset_wr_addr", {12'd0, mem_wr_addr}, 32'd0);
      check("midreset_wr_data", {24'd0, mem_wr_data}, 32'd0);
      check("midreset_busy", {31'd0, busy}, 32'd0);
      check("midreset_frame_done", {31'd0, frame_done}, 32'd0);
      m_running = 1'b0;
      m_done    = 1'b0;
      m_valid   = 1'b0;
      fifo_q.delete();
      update_pins();
      #2;
      reset = 1'b1;
      @(posedge clock);
      #1;
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      run_frame('{preload: 12, feed_period: 0, feed_count: 0, ready_mode: 0, extra_start: 1'b0, exp_writes: 12, exp_done: 1, exp_left: 0});
    end

    // randomized frames
    for (int k = 0; k < 4; k++) begin
      scen_t r;
      int left;
      int pre;
      int fc;
      left = fifo_q.size();
      pre  = $urandom_range(0, 14);
      fc   = (left + pre >= TOTAL) ? 0 : TOTAL - left - pre;
      r = '{preload: pre, feed_period: $urandom_range(1, 4), feed_count: fc, ready_mode: 2,
            extra_start: 1'($urandom_range(0, 1)), exp_writes: 12, exp_done: 1,
            exp_left: left + pre + fc - TOTAL};
      run_frame(r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sobel_frame_writer.md
# sobel_frame_writer

Drains the sobel output FIFO of the edge-detection pipeline and writes each pixel into a frame memory write port at sequential addresses. It sits downstream of `dut_system`, driving `fifo_sobel_rd_en` from `fifo_sobel_dout`/`fifo_sobel_empty`. A start pulse arms one frame of IMG_WIDTH×IMG_HEIGHT pixels. After the last write is accepted, the block reports frame completion and returns to idle.

## Interface
- IMG_WIDTH, 720, pixels per row
- IMG_HEIGHT, 540, rows per frame
- DWIDTH, 8, pixel width; equals the sobel FIFO data width
- ADDR_WIDTH, 20, memory address width; must satisfy 2^ADDR_WIDTH ≥ IMG_WIDTH·IMG_HEIGHT
- clock  in  1  single clock; all logic on its rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; arms a frame when idle
- fifo_in_rd_en  out  1  pops the FIFO head this cycle
- fifo_in_dout  in  DWIDTH  FIFO head data (show-ahead; valid while fifo_in_empty=0)
- fifo_in_empty  in  1  FIFO has no data
- mem_wr_en  out  1  write request valid
- mem_wr_addr  out  ADDR_WIDTH  write address
- mem_wr_data  out  DWIDTH  write data
- mem_ready  in  1  memory accepts the request this cycle when mem_wr_en=1
- busy  out  1  high in RUN
- frame_done  out  1  one-cycle pulse after the final write is accepted

## Operation
- Reset (reset=0, asynchronous): state=IDLE, pop_count=0, wr_addr=0. All outputs are 0: fifo_in_rd_en, mem_wr_en, mem_wr_addr, mem_wr_data, busy, frame_done.
- **IDLE**
  - fifo_in_rd_en=0.
  - start=1 → RUN; pop_count and wr_addr clear to 0.
- **RUN**
  - busy=1.
  - Output register: mem_wr_en, mem_wr_addr and mem_wr_data form one holding stage. The stage is free when mem_wr_en=0 or mem_ready=1.
  - Pop condition (combinational): fifo_in_rd_en = (state=RUN) & ~fifo_in_empty & (pop_count < IMG_WIDTH·IMG_HEIGHT) & stage_free.
  - On a pop: at the next edge, mem_wr_data ← fifo_in_dout, mem_wr_addr ← pop_count, mem_wr_en ← 1, and pop_count increments.
  - If the stage is free but no pop occurs, mem_wr_en ← 0.
  - If the stage is not free (mem_wr_en=1, mem_ready=0), all three outputs hold unchanged.
  - When the accepted write is at address IMG_WIDTH·IMG_HEIGHT−1 (mem_wr_en & mem_ready & addr=last) → DONE.
- **DONE**
  - frame_done=1 and busy=0 for exactly one cycle, then → IDLE.
  - mem_wr_en=0.
- start is ignored outside IDLE.
- No pops occur after the frame count is reached. Surplus FIFO data stays in the FIFO for the next frame.
- pop_count is wide enough to hold IMG_WIDTH·IMG_HEIGHT. Addresses never wrap within a frame.
- Data is transferred unmodified; no arithmetic is applied to pixels.

## Timing
- Pop in cycle N → mem_wr_en=1 with that pixel from cycle N+1.
- Throughput is 1 pixel/cycle while FIFO is non-empty and mem_ready=1.
- A pop and an accepted write in the same cycle are allowed (stage refill).
- The final write is accepted in cycle M → frame_done=1 in cycle M+1 → IDLE in M+2. A start in M+2 is honored.
- Minimum frame time: 1 (start) + W·H + 1 cycles.
- Reset asserted mid-frame: outputs go to 0 immediately (asynchronous). No frame_done is issued. The state after reset release is IDLE.
- fifo_in_empty=1 with the stage full: the stage drains on mem_ready. Data is never dropped or duplicated.

## Test plan
- W=4, H=3, mem_ready=1, FIFO preloaded with 0x00..0x0B, start pulse
  - → 12 writes, addr 0..11 with data 0x00..0x0B on consecutive cycles
  - → frame_done 1 cycle after the addr-11 write; busy low afterwards.
- Same frame with mem_ready toggled 1,0,0,1 repeating
  - → each write held stable while mem_ready=0; no pop while the stage is full
  - → exact 12-write sequence; frame_done once.
- FIFO fed one pixel every 3 cycles → mem_wr_en gaps match FIFO empties; addresses stay contiguous 0..11.
- FIFO preloaded with 15 pixels, one frame
  - → exactly 12 pops; 3 pixels remain (empty=0, rd_en=0 after the 12th pop)
  - → a second start writes the remaining pixels from addr 0.
- Second start pulse during RUN → ignored; pop_count is unaffected; single frame_done.
- reset=0 after the 5th write → all outputs 0 in the same cycle, state IDLE. A new start after release restarts at addr 0.
